// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and iteration count shared by the ALU.
// Used by alu_mc and alu_mul_iter; the multiplier needs ALU_MUL_EN.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SLL = 4'd5,
    OP_SRL = 4'd6,
    OP_SRA = 4'd7,
    OP_MUL = 4'd8
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  localparam int MUL_STEPS = 32;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: unsigned shift-add multiplier, one bit per clock, LSB first.
// Only instantiated when ALU_MUL_EN is defined.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic               load,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] prod,
  output logic               last
);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplr;
  logic [5:0]         cnt;

  // prod is the accumulator after the step taken on the coming edge
  always_comb begin
    prod = acc + (mplr[0] ? mcand : '0);
  end

  assign last = (cnt == 6'(MUL_STEPS - 1));

  // capture operands on load, then one add/shift per clock until done
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
      cnt   <= '0;
    end else if (load) begin
      acc   <= '0;
      mcand <= {{WIDTH{1'b0}}, a};
      mplr  <= b;
      cnt   <= '0;
    end else if (cnt < 6'(MUL_STEPS)) begin
      acc   <= prod;
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
      cnt   <= cnt + 6'd1;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with zf/sf/cf flags and start/done handshake.
// Define ALU_MUL_EN to build the iterative MUL; otherwise opcode 8 is illegal.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             sf,
  output logic             cf,
  output logic             done,
  output logic             flag_we,
  output logic             busy,
  output logic             err
);

  state_e           state, nstate;
  logic             fin, bad, legal, is_mul;
  logic [WIDTH:0]   sum;
  logic [4:0]       sh;
  logic [WIDTH-1:0] sres, ures;
  logic             scf, ucf;

`ifdef ALU_MUL_EN
  logic               load, last;
  logic [2*WIDTH-1:0] prod;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk  (clk),
    .clrn (clrn),
    .load (load),
    .a    (a),
    .b    (b),
    .prod (prod),
    .last (last)
  );

  assign is_mul = (op == OP_MUL);
  assign busy   = (state == ST_MUL);
  assign legal  = (op <= OP_MUL);
`else
  assign is_mul = 1'b0;
  assign busy   = 1'b0;
  assign legal  = (op <= OP_SRA);
`endif

  // single-cycle datapath and its carry/borrow/shift-out flag
  always_comb begin
    sum  = '0;
    sres = '0;
    scf  = 1'b0;
    sh   = b[4:0];
    case (op)
      OP_ADD: begin
        sum  = {1'b0, a} + {1'b0, b};
        sres = sum[WIDTH-1:0];
        scf  = sum[WIDTH];
      end
      OP_SUB: begin
        sum  = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        sres = sum[WIDTH-1:0];
        scf  = ~sum[WIDTH];
      end
      OP_AND: sres = a & b;
      OP_OR:  sres = a | b;
      OP_XOR: sres = a ^ b;
      OP_SLL: begin
        sres = a << sh;
        scf  = (sh != 5'd0) && a[~sh + 5'd1];
      end
      OP_SRL: begin
        sres = a >> sh;
        scf  = (sh != 5'd0) && a[sh - 5'd1];
      end
      OP_SRA: begin
        sres = WIDTH'($signed(a) >>> sh);
        scf  = (sh != 5'd0) && a[sh - 5'd1];
      end
      default: ;
    endcase
  end

  // select the value written back: multiplier product or simple result
  always_comb begin
    ures = sres;
    ucf  = scf;
`ifdef ALU_MUL_EN
    if (state == ST_MUL) begin
      ures = prod[WIDTH-1:0];
      ucf  = |prod[2*WIDTH-1:WIDTH];
    end
`endif
  end

  // state register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= ST_IDLE;
    else       state <= nstate;
  end

  // next state and completion control
  always_comb begin
    nstate = state;
    fin    = 1'b0;
    bad    = 1'b0;
`ifdef ALU_MUL_EN
    load   = 1'b0;
`endif
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (is_mul) begin
            nstate = ST_MUL;
`ifdef ALU_MUL_EN
            load   = 1'b1;
`endif
          end else begin
            fin = 1'b1;
            bad = ~legal;
          end
        end
      end
      ST_MUL: begin
`ifdef ALU_MUL_EN
        if (last) begin
          nstate = ST_IDLE;
          fin    = 1'b1;
        end
`else
        nstate = ST_IDLE;
`endif
      end
      default: nstate = ST_IDLE;
    endcase
  end

  // registered outputs; illegal ops leave result and flags untouched
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      result  <= '0;
      zf      <= 1'b0;
      sf      <= 1'b0;
      cf      <= 1'b0;
      done    <= 1'b0;
      flag_we <= 1'b0;
      err     <= 1'b0;
    end else begin
      done    <= fin;
      err     <= bad;
      flag_we <= fin & ~bad;
      if (fin && !bad) begin
        result <= ures;
        zf     <= (ures == '0);
        sf     <= ures[WIDTH-1];
        cf     <= ucf;
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed vectors with a scoreboard queue and done monitor.
// Covers the MUL path when ALU_MUL_EN is defined, else opcode 8 as illegal.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        clrn;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic [31:0] result;
  logic        zf, sf, cf, done, flag_we, busy, err;

  typedef struct {
    logic [31:0] r;
    logic        z, s, c, fw, e;
    int          c0, lat;
  } exp_t;

  exp_t        q[$];
  int          ntests = 0;
  int          nfail  = 0;
  int          cyc    = 0;
  logic [31:0] pr = '0;
  logic        pz = 1'b0, ps = 1'b0, pc = 1'b0;

  alu_mc #(.WIDTH(32)) dut (
    .clk     (clk),
    .clrn    (clrn),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .result  (result),
    .zf      (zf),
    .sf      (sf),
    .cf      (cf),
    .done    (done),
    .flag_we (flag_we),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", n, act, exp);
    end
  endtask

  // monitor: every completion pops one expected entry
  always @(negedge clk) begin
    if (clrn && (done || flag_we || err)) begin
      if (q.size() == 0) begin
        ntests++;
        nfail++;
        $display("FAIL unexpected_done: done=%b flag_we=%b err=%b", done, flag_we, err);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done",    32'(done),    32'd1);
        chk("result",  result,       e.r);
        chk("zf",      32'(zf),      32'(e.z));
        chk("sf",      32'(sf),      32'(e.s));
        chk("cf",      32'(cf),      32'(e.c));
        chk("flag_we", 32'(flag_we), 32'(e.fw));
        chk("err",     32'(err),     32'(e.e));
        chk("latency", 32'(cyc - e.c0), 32'(e.lat));
      end
    end
  end

  task automatic drive(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
  endtask

  task automatic run(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] r, input logic z, input logic s,
                     input logic c, input int lat);
    exp_t e;
    drive(o, x, y);
    e = '{r: r, z: z, s: s, c: c, fw: 1'b1, e: 1'b0, c0: cyc, lat: lat};
    q.push_back(e);
    pr = r; pz = z; ps = s; pc = c;
    @(negedge clk);
  endtask

  task automatic bad(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    drive(o, x, y);
    e = '{r: pr, z: pz, s: ps, c: pc, fw: 1'b0, e: 1'b1, c0: cyc, lat: 1};
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_result"}, result, 32'd0);
    chk({n, "_flags"},  {29'd0, zf, sf, cf}, 32'd0);
    chk({n, "_ctl"},    {28'd0, done, flag_we, busy, err}, 32'd0);
  endtask

  initial begin
    clrn = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    clrn = 1'b1;
    @(negedge clk);

    // back-to-back simple ops
    run(4'd0, 32'hFFFFFFFF, 32'h1,        32'h0,        1, 0, 1, 1);
    run(4'd0, 32'h7,        32'h8,        32'hF,        0, 0, 0, 1);
    run(4'd1, 32'h3,        32'h5,        32'hFFFFFFFE, 0, 1, 1, 1);
    run(4'd1, 32'h5,        32'h5,        32'h0,        1, 0, 0, 1);
    run(4'd2, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 1, 0, 1);
    run(4'd3, 32'h0000000F, 32'h000000F0, 32'h000000FF, 0, 0, 0, 1);
    run(4'd4, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h0,        1, 0, 0, 1);
    run(4'd5, 32'h80000001, 32'h1,        32'h2,        0, 0, 1, 1);
    run(4'd7, 32'h80000000, 32'd31,       32'hFFFFFFFF, 0, 1, 0, 1);
    run(4'd6, 32'h12345678, 32'h0,        32'h12345678, 0, 0, 0, 1);
    run(4'd6, 32'h3,        32'h1,        32'h1,        0, 0, 1, 1);
    run(4'd5, 32'h80000000, 32'h20,       32'h80000000, 0, 1, 0, 1);
    bad(4'hF, 32'h1, 32'h1);
    bad(4'h9, 32'h2, 32'h3);
    idle(2);

`ifdef ALU_MUL_EN
    // MUL with starts pulsed while busy, and operands changed mid-flight
    run(4'd8, 32'h10000, 32'h10000, 32'h0, 1, 0, 1, 33);
    drive(4'd0, 32'h1, 32'h2);
    chk("busy_during_mul", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    a = 32'hDEAD; b = 32'hBEEF;
    idle(30);
    chk("busy_after_mul", 32'(busy), 32'd0);

    // start accepted in the done cycle
    run(4'd8, 32'd7, 32'd6, 32'd42, 0, 0, 0, 33);
    idle(32);
    run(4'd0, 32'd2, 32'd3, 32'd5, 0, 0, 0, 1);
    run(4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 0, 0, 1, 33);
    idle(34);

    // reset in the middle of a MUL aborts it silently
    run(4'd0, 32'd7, 32'd8, 32'hF, 0, 0, 0, 1);
    drive(4'd8, 32'd3, 32'd3);
    @(negedge clk);
    idle(9);
    #2 clrn = 1'b0;
    #1 chk_zero("reset_mid_mul");
    pr = '0; pz = 1'b0; ps = 1'b0; pc = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clrn = 1'b1;
    idle(40);
    chk("busy_after_abort", 32'(busy), 32'd0);
    run(4'd0, 32'h1, 32'h1, 32'h2, 0, 0, 0, 1);
    bad(4'hF, 32'h0, 32'h0);
    idle(2);
`else
    // opcode 8 is illegal without the multiplier
    run(4'd0, 32'd7, 32'd8, 32'hF, 0, 0, 0, 1);
    bad(4'd8, 32'h10000, 32'h10000);
    idle(2);
    chk("busy_tied", 32'(busy), 32'd0);
`endif

    for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      ntests++;
      nfail++;
      $display("FAIL drain: %0d pending, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
